// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and sizing helpers for the preload FIFO
package sync_fifo_pkg;

  typedef enum logic {PRIME, STREAM} fifo_state_t;

  localparam int ERR_CNT_W = 16;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DEPTH x (WIDTH+1) storage, sync write, async read
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH:0]           rdata
);

  logic [WIDTH:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_preload_fifo.sv
// rtl/sync_preload_fifo.sv - packet-aware single-clock FIFO with preload threshold
// Optional error counters: define SYNC_FIFO_ERR_CNT_EN.
module sync_preload_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int PRELOAD      = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
`ifdef SYNC_FIFO_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]     ovf_cnt,
  output logic [ERR_CNT_W-1:0]     unf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] DEPTH_L   = PW'(DEPTH);
  localparam logic [PW-1:0] PRELOAD_L = PW'(PRELOAD);
  localparam logic [PW-1:0] AFULL_L   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] ONE       = PW'(1);

  logic [PW-1:0] wr_ptr, rd_ptr, last_cnt, last_cnt_nxt, lvl_nxt;
  logic [WIDTH:0] rd_word;
  logic           wr_en, rd_en, inc_last, dec_last;
  fifo_state_t    state, state_nxt;

  sync_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en && !clr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({in_last, in_data}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == DEPTH_L);
  assign empty       = (level == '0);
  assign almost_full = (level >= AFULL_L);
  assign in_ready    = !full;
  assign wr_en       = in_valid && in_ready;
  assign overflow    = in_valid && !in_ready;

  assign out_valid = (state == STREAM) && !empty;
  assign rd_en     = out_valid && out_ready;
  assign out_data  = out_valid ? rd_word[WIDTH-1:0] : '0;
  assign out_last  = out_valid && rd_word[WIDTH];

  assign inc_last     = wr_en && in_last;
  assign dec_last     = rd_en && rd_word[WIDTH];
  assign last_cnt_nxt = last_cnt + {{(PW-1){1'b0}}, inc_last} - {{(PW-1){1'b0}}, dec_last};
  assign lvl_nxt      = level + {{(PW-1){1'b0}}, wr_en} - {{(PW-1){1'b0}}, rd_en};

  // Priming looks at post-write counts so a word written in cycle N can be offered at N+1.
  always_comb begin
    state_nxt = state;
    underflow = 1'b0;
    case (state)
      PRIME: begin
        if (lvl_nxt >= PRELOAD_L || last_cnt_nxt != '0) state_nxt = STREAM;
      end
      STREAM: begin
        if (dec_last && last_cnt == ONE) begin
          state_nxt = PRIME;
        end else if (empty && last_cnt == '0) begin
          state_nxt = PRIME;
          underflow = 1'b1;
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_cnt <= '0;
      state    <= PRIME;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_cnt <= '0;
      state    <= PRIME;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      last_cnt <= last_cnt_nxt;
      state    <= state_nxt;
    end
  end

`ifdef SYNC_FIFO_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (overflow && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
      if (underflow && unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_preload_fifo.sv
// tb/tb_sync_preload_fifo.sv - directed self-checking bench for sync_preload_fifo
module tb_sync_preload_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;

  logic         a_in_valid, a_in_last, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic         a_in_ready, a_out_valid, a_out_last, a_full, a_empty, a_afull, a_ovf, a_unf;
  logic [4:0]   a_level;

  logic         b_in_valid, b_in_last, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic         b_in_ready, b_out_valid, b_out_last, b_full, b_empty, b_afull, b_ovf, b_unf;
  logic [4:0]   b_level;

`ifdef SYNC_FIFO_ERR_CNT_EN
  logic [15:0] a_ovf_cnt, a_unf_cnt, b_ovf_cnt, b_unf_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int wi, ri;

  always #5 clk = ~clk;

  sync_preload_fifo #(.WIDTH(W), .DEPTH(D), .PRELOAD(2), .AFULL_THRESH(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .level(a_level), .full(a_full), .empty(a_empty), .almost_full(a_afull),
    .overflow(a_ovf), .underflow(a_unf)
`ifdef SYNC_FIFO_ERR_CNT_EN
    , .ovf_cnt(a_ovf_cnt), .unf_cnt(a_unf_cnt)
`endif
  );

  sync_preload_fifo #(.WIDTH(W), .DEPTH(D), .PRELOAD(4), .AFULL_THRESH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .level(b_level), .full(b_full), .empty(b_empty), .almost_full(b_afull),
    .overflow(b_ovf), .underflow(b_unf)
`ifdef SYNC_FIFO_ERR_CNT_EN
    , .ovf_cnt(b_ovf_cnt), .unf_cnt(b_unf_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // Reset state
    check("rst_level", a_level, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out", {a_out_valid, a_out_last, a_out_data}, 0);
    check("rst_flags", {a_ovf, a_unf, a_afull}, 0);

    // Preload of two words
    a_in_valid = 1; a_in_data = 8'hA1; tick();
    a_in_valid = 0; #1;
    check("t2_level1", a_level, 1);
    check("t2_primed", a_out_valid, 0);
    a_in_valid = 1; a_in_data = 8'hA2; tick();
    a_in_valid = 0; #1;
    check("t2_valid", a_out_valid, 1);
    check("t2_data", a_out_data, 8'hA1);

    // Asynchronous reset mid-stream, then clear with a competing write
    rst_n = 0; #1;
    check("t1_arst_level", a_level, 0);
    check("t1_arst_out", {a_out_valid, a_out_data}, 0);
    tick(); rst_n = 1; tick();
    a_in_valid = 1; a_in_data = 8'hB0; tick();
    check("t1_pre_clr_level", a_level, 1);
    clr = 1; tick();
    clr = 0; a_in_valid = 0; #1;
    check("t1_clr_level", a_level, 0);
    check("t1_clr_flags", {a_empty, a_in_ready, a_out_valid, a_afull}, 4'b1100);

    // Short packet released before PRELOAD=4
    b_in_valid = 1; b_in_data = 8'h55; b_in_last = 1; tick();
    b_in_valid = 0; b_in_last = 0; #1;
    check("t3_out", {b_out_valid, b_out_last, b_out_data}, {2'b11, 8'h55});
    b_out_ready = 1; tick();
    b_out_ready = 0; #1;
    check("t3_done", {b_out_valid, b_unf, b_level}, 0);
    b_in_valid = 1; b_in_data = 8'h66; tick();
    b_in_valid = 0; #1;
    check("t3_reprime", {b_out_valid, b_level}, 1);

    // Fill to full, 17th word dropped
    a_out_ready = 0;
    for (int i = 0; i < 17; i++) begin
      a_in_valid = 1; a_in_data = 8'(i); #1;
      if (i == 16) check("t4_ovf_ready", {a_ovf, a_in_ready}, 2'b10);
      tick();
      if (i == 10) check("t4_afull_11", a_afull, 0);
      if (i == 11) check("t4_afull_12", a_afull, 1);
    end
    a_in_valid = 0; #1;
    check("t4_full", {a_full, a_level}, {1'b1, 5'd16});
    check("t4_ovf_clear", a_ovf, 0);
    a_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("t4_drain", {a_out_valid, a_out_data}, {1'b1, 8'(i)});
      tick();
    end
    check("t4_unf", {a_empty, a_unf}, 2'b11);
    a_out_ready = 0; tick();
    check("t4_unf_off", a_unf, 0);
`ifdef SYNC_FIFO_ERR_CNT_EN
    check("t4_cnts", {a_ovf_cnt, a_unf_cnt}, {16'd1, 16'd1});
`endif

    // Underflow: two words without last, three read attempts
    clr = 1; tick(); clr = 0;
    a_in_valid = 1; a_in_data = 8'h10; tick();
    a_in_data = 8'h11; tick();
    a_in_valid = 0; a_out_ready = 1; #1;
    check("t6_rd0", {a_out_valid, a_out_data, a_unf}, {1'b1, 8'h10, 1'b0});
    tick();
    check("t6_rd1", {a_out_valid, a_out_data, a_unf}, {1'b1, 8'h11, 1'b0});
    tick();
    check("t6_rd2", {a_out_valid, a_unf}, 2'b01);
    tick();
    check("t6_prime", {a_out_valid, a_unf}, 0);
`ifdef SYNC_FIFO_ERR_CNT_EN
    check("t6_cnts", {a_ovf_cnt, a_unf_cnt}, {16'd0, 16'd1});
`endif
    a_out_ready = 0;

    // Wrap: 40 words, reader ready every other cycle
    clr = 1; tick(); clr = 0;
    wi = 0; ri = 0;
    for (int c = 0; c < 400 && ri < 40; c++) begin
      a_in_valid = (wi < 40); a_in_data = 8'(wi); a_out_ready = c[0]; #1;
      if (a_out_valid && a_out_ready) begin
        check("t5_order", a_out_data, ri);
        ri++;
      end
      if (a_in_valid && a_in_ready) wi++;
      tick();
    end
    a_in_valid = 0; a_out_ready = 0;
    check("t5_count", ri, 40);
    check("t5_written", wi, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
